// File: rtl/cmd_dispatch.sv
// Command dispatcher: parses a header word (cmd id + argument count) from a
// 32-bit word stream, buffers the arguments, presents the command to a unit
// and waits (bounded by a timeout) for the unit to report completion.
// Oversized commands are drained from the stream and flagged.
module cmd_dispatch #(
  parameter int unsigned CMD_BITS = 8,
  parameter int unsigned MAX_ARGS = 8,
  parameter int unsigned TIMEOUT  = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [CMD_BITS-1:0] cmd,
  output logic                cmd_ready,
  input  logic                cmd_done,
  output logic [31:0]         arg_data,
  input  logic                arg_advance,
  output logic                err_nargs,
  output logic                err_timeout
);

  localparam int unsigned AW = (MAX_ARGS > 1) ? $clog2(MAX_ARGS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [8:0]    NARGS_MAX = 9'(MAX_ARGS);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DISPATCH,
    S_DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [CMD_BITS-1:0] cmd_q, cmd_d;
  logic [7:0]          nargs_q, nargs_d;
  logic [7:0]          wr_ptr_q, wr_ptr_d;  // words accepted so far (LOAD and DRAIN)
  logic [7:0]          rd_ptr_q, rd_ptr_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                err_nargs_q, err_nargs_d;
  logic                err_timeout_q, err_timeout_d;
  logic                mem_we;
  logic [31:0]         arg_mem [MAX_ARGS];

  logic [CMD_BITS-1:0] hdr_cmd;
  logic [7:0]          hdr_nargs;
  logic                accept;

  assign hdr_cmd   = in_data[CMD_BITS-1:0];
  assign hdr_nargs = in_data[CMD_BITS+7:CMD_BITS];

  // Stream is held off while a command is with the unit, and while in reset.
  assign in_ready  = !rst && (state_q != S_DISPATCH);
  assign accept    = in_valid && in_ready;

  // Dropping cmd_ready in the cmd_done cycle stops the unit from consuming
  // a stale argument on its way out.
  assign cmd_ready = (state_q == S_DISPATCH) && !cmd_done;

  assign arg_data  = ((state_q == S_DISPATCH) && (rd_ptr_q < nargs_q))
                     ? arg_mem[rd_ptr_q[AW-1:0]] : 32'h0;

  assign cmd         = cmd_q;
  assign err_nargs   = err_nargs_q;
  assign err_timeout = err_timeout_q;

  // Next-state logic: header decode, argument load/drain, dispatch and timeout.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d       = state_q;
    cmd_d         = cmd_q;
    nargs_d       = nargs_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    tmo_d         = tmo_q;
    err_nargs_d   = err_nargs_q;
    err_timeout_d = err_timeout_q;
    mem_we        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cmd_d    = hdr_cmd;
          nargs_d  = hdr_nargs;
          wr_ptr_d = '0;
          if (hdr_nargs == 8'd0) begin
            state_d  = S_DISPATCH;
            rd_ptr_d = '0;
            tmo_d    = '0;
          end else if (9'(hdr_nargs) > NARGS_MAX) begin
            err_nargs_d = 1'b1;
            state_d     = S_DRAIN;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (accept) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 8'd1;
          if (wr_ptr_q + 8'd1 == nargs_q) begin
            state_d  = S_DISPATCH;
            rd_ptr_d = '0;
            tmo_d    = '0;
          end
        end
      end

      S_DRAIN: begin
        if (accept) begin
          wr_ptr_d = wr_ptr_q + 8'd1;
          if (wr_ptr_q + 8'd1 == nargs_q) begin
            state_d = S_IDLE;
          end
        end
      end

      S_DISPATCH: begin
        if (cmd_ready && arg_advance && (rd_ptr_q < nargs_q)) begin
          rd_ptr_d = rd_ptr_q + 8'd1;
        end
        // Completion takes priority over a timeout expiring in the same cycle.
        if (cmd_done) begin
          state_d = S_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q       <= S_IDLE;
      cmd_q         <= '0;
      nargs_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      tmo_q         <= '0;
      err_nargs_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      nargs_q       <= nargs_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      tmo_q         <= tmo_d;
      err_nargs_q   <= err_nargs_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Argument buffer write port.
  always_ff @(posedge clk) begin
    // NOTE: the buffer has no reset; entries are only read after being written.
    if (mem_we) begin
      arg_mem[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

endmodule

// File: tb/tb_cmd_dispatch.sv
// Self-checking bench for cmd_dispatch: directed table, hand-written corner
// sequences, and a random run against a transaction-level reference model.
module tb_cmd_dispatch;

  localparam int CMD_BITS = 8;
  localparam int MAX_ARGS = 8;
  localparam int TIMEOUT  = 16;

  logic                clk;
  logic                rst;
  logic [31:0]         in_data;
  logic                in_valid;
  logic                in_ready;
  logic [CMD_BITS-1:0] cmd;
  logic                cmd_ready;
  logic                cmd_done;
  logic [31:0]         arg_data;
  logic                arg_advance;
  logic                err_nargs;
  logic                err_timeout;

  int n_checks = 0;
  int n_errors = 0;

  cmd_dispatch #(
    .CMD_BITS(CMD_BITS),
    .MAX_ARGS(MAX_ARGS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cmd        (cmd),
    .cmd_ready  (cmd_ready),
    .cmd_done   (cmd_done),
    .arg_data   (arg_data),
    .arg_advance(arg_advance),
    .err_nargs  (err_nargs),
    .err_timeout(err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  // ---------------- reference model (transaction level) ----------------
  // The model tracks "words still owed by the stream" and "a command is with
  // the unit", and holds the accepted arguments in a queue.
  bit          m_busy;
  int          m_need;
  bit          m_discard;
  logic [31:0] m_args[$];
  int          m_rd;
  int          m_age;
  logic [7:0]  m_cmd;
  bit          m_err_n;
  bit          m_err_t;

  task automatic model_reset();
    m_busy = 0; m_need = 0; m_discard = 0; m_args.delete();
    m_rd = 0; m_age = 0; m_cmd = '0; m_err_n = 0; m_err_t = 0;
  endtask

  task automatic model_start();
    m_busy = 1; m_rd = 0; m_age = 0;
  endtask

  // Advance the model by one clock using the inputs held across the edge.
  task automatic model_step();
    int n;
    if (m_busy) begin
      if (cmd_done) begin
        m_busy = 0;
      end else begin
        if (arg_advance && m_rd < m_args.size()) m_rd++;
        if (m_age + 1 == TIMEOUT) begin
          m_err_t = 1;
          m_busy  = 0;
        end else begin
          m_age++;
        end
      end
    end else if (in_valid) begin
      if (m_need == 0) begin
        m_cmd = in_data[7:0];
        n     = int'(in_data[15:8]);
        m_args.delete();
        if (n == 0) begin
          model_start();
        end else begin
          m_need    = n;
          m_discard = (n > MAX_ARGS);
          if (m_discard) m_err_n = 1;
        end
      end else begin
        if (!m_discard) m_args.push_back(in_data);
        m_need--;
        if (m_need == 0 && !m_discard) model_start();
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs (at posedge+1), let them settle, compare to model.
  task automatic apply(input logic v, input logic [31:0] d, input logic done, input logic adv);
    logic [31:0] exp_arg;
    in_valid    = v;
    in_data     = d;
    cmd_done    = done;
    arg_advance = adv;
    #3;
    exp_arg = (m_busy && m_rd < m_args.size()) ? m_args[m_rd] : 32'h0;
    check("model_in_ready",    in_ready,    !m_busy);
    check("model_cmd_ready",   cmd_ready,   m_busy && !done);
    check("model_arg_data",    arg_data,    exp_arg);
    check("model_cmd",         cmd,         m_cmd);
    check("model_err_nargs",   err_nargs,   m_err_n);
    check("model_err_timeout", err_timeout, m_err_t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  // Assert reset between edges, check forced values, release away from an edge.
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; cmd_done = 1'b0; arg_advance = 1'b0;
    #1;
    check("rst_in_ready",    in_ready,    1'b0);
    check("rst_cmd_ready",   cmd_ready,   1'b0);
    check("rst_arg_data",    arg_data,    32'h0);
    check("rst_cmd",         cmd,         8'h0);
    check("rst_err_nargs",   err_nargs,   1'b0);
    check("rst_err_timeout", err_timeout, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] hdr(input int c, input int n);
    logic [31:0] h;
    h = '0;
    h[7:0]  = 8'(c);
    h[15:8] = 8'(n);
    return h;
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        done;
    logic        adv;
    logic        e_in_ready;
    logic        e_cmd_ready;
    logic [31:0] e_arg;
    logic [7:0]  e_cmd;
  } vec_t;

  vec_t tbl [19];

  initial begin
    int          cnt;
    bit          found;
    logic [31:0] acc[$];
    logic        v;
    logic [31:0] d;
    int          r;
    int          n;

    // cmd=2 nargs=4 with advance every cycle, done 5 cycles after cmd_ready,
    // then a queued cmd=3 nargs=2 held on the stream during dispatch.
    tbl[0]  = '{1'b1, 32'h0000_0402, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         8'h00};
    tbl[1]  = '{1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         8'h02};
    tbl[2]  = '{1'b1, 32'h0000_03E8, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         8'h02};
    tbl[3]  = '{1'b1, 32'h0000_01F4, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         8'h02};
    tbl[4]  = '{1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         8'h02};
    tbl[5]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h5,         8'h02};
    tbl[6]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h3E8,       8'h02};
    tbl[7]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h1F4,       8'h02};
    tbl[8]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h1,         8'h02};
    tbl[9]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         8'h02};
    tbl[10] = '{1'b1, 32'h0000_0203, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         8'h02};
    tbl[11] = '{1'b1, 32'h0000_0203, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         8'h02};
    tbl[12] = '{1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         8'h03};
    tbl[13] = '{1'b1, 32'hBBBB_0002, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         8'h03};
    tbl[14] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA_0001, 8'h03};
    tbl[15] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'hAAAA_0001, 8'h03};
    tbl[16] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'hBBBB_0002, 8'h03};
    tbl[17] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         8'h03};
    tbl[18] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         8'h03};

    model_reset();
    do_reset();

    for (int i = 0; i < 19; i++) begin
      apply(tbl[i].v, tbl[i].d, tbl[i].done, tbl[i].adv);
      check($sformatf("tbl%0d_in_ready", i),  in_ready,  tbl[i].e_in_ready);
      check($sformatf("tbl%0d_cmd_ready", i), cmd_ready, tbl[i].e_cmd_ready);
      check($sformatf("tbl%0d_arg_data", i),  arg_data,  tbl[i].e_arg);
      check($sformatf("tbl%0d_cmd", i),       cmd,       tbl[i].e_cmd);
      tick();
    end

    // Oversized header (12 > 8): 12 words discarded, then cmd=2 nargs=0 runs.
    apply(1'b1, hdr(1, 12), 1'b0, 1'b0);
    tick();
    check("nargs12_err_set", err_nargs, 1'b1);
    for (int i = 0; i < 12; i++) begin
      apply(1'b1, 32'hD000_0000 + 32'(i), 1'b0, 1'b1);
      check("nargs12_drain_ready", in_ready, 1'b1);
      check("nargs12_no_dispatch", cmd_ready, 1'b0);
      tick();
    end
    apply(1'b1, hdr(2, 0), 1'b0, 1'b0);
    check("nargs12_hdr_ready", in_ready, 1'b1);
    tick();
    apply(1'b0, 32'h0, 1'b0, 1'b0);
    check("nargs12_next_cmd", cmd, 8'h02);
    check("nargs12_next_dispatch", cmd_ready, 1'b1);
    check("nargs12_err_sticky", err_nargs, 1'b1);
    tick();
    apply(1'b0, 32'h0, 1'b1, 1'b0);
    tick();

    // nargs=3 with in_valid toggling: only accepted words stored, in order.
    apply(1'b1, hdr(5, 3), 1'b0, 1'b0);
    tick();
    found = 0;
    for (int i = 0; i < 60; i++) begin
      v = 1'($urandom_range(0, 1));
      d = $urandom;
      apply(v, d, 1'b0, 1'b0);
      if (cmd_ready) begin
        found = 1;
        tick();
        break;
      end
      if (v && in_ready) acc.push_back(d);
      tick();
    end
    check("toggle_dispatch_reached", 32'(found), 32'd1);
    check("toggle_words_accepted", 32'(acc.size()), 32'd3);
    if (found && acc.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        apply(1'b0, 32'h0, 1'b0, 1'b1);
        check($sformatf("toggle_arg%0d", i), arg_data, acc[i]);
        tick();
      end
    end
    apply(1'b0, 32'h0, 1'b1, 1'b0);
    tick();

    // Timeout: unit never finishes; cmd_ready must be high exactly TIMEOUT cycles.
    apply(1'b1, hdr(7, 0), 1'b0, 1'b0);
    tick();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      apply(1'b0, 32'h0, 1'b0, 1'b0);
      if (!cmd_ready) break;
      cnt++;
      tick();
    end
    check("timeout_ready_cycles", 32'(cnt), 32'(TIMEOUT));
    check("timeout_err_set", err_timeout, 1'b1);
    check("timeout_back_idle", in_ready, 1'b1);
    tick();

    // Reset in the middle of a dispatch with both error flags set.
    apply(1'b1, hdr(9, 0), 1'b0, 1'b0);
    tick();
    apply(1'b0, 32'h0, 1'b0, 1'b0);
    check("midrst_pre_ready", cmd_ready, 1'b1);
    check("midrst_pre_errs", {err_nargs, err_timeout}, 2'b11);
    tick();
    do_reset();
    apply(1'b1, hdr(10, 1), 1'b0, 1'b0);
    check("midrst_hdr_ready", in_ready, 1'b1);
    tick();
    apply(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    tick();
    apply(1'b0, 32'h0, 1'b0, 1'b0);
    check("midrst_next_ready", cmd_ready, 1'b1);
    check("midrst_next_arg", arg_data, 32'h1234_5678);
    check("midrst_next_cmd", cmd, 8'h0A);
    tick();
    apply(1'b0, 32'h0, 1'b1, 1'b0);
    tick();

    // cmd_done in the cycle the timeout would fire: done wins, no error.
    apply(1'b1, hdr(11, 0), 1'b0, 1'b0);
    tick();
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      apply(1'b0, 32'h0, 1'b0, 1'b0);
      tick();
    end
    apply(1'b0, 32'h0, 1'b1, 1'b0);
    check("done_last_ready_low", cmd_ready, 1'b0);
    tick();
    apply(1'b0, 32'h0, 1'b0, 1'b0);
    check("done_last_no_err", err_timeout, 1'b0);
    check("done_last_idle", in_ready, 1'b1);
    tick();

    // Random traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = $urandom;
      if (!m_busy && m_need == 0) begin
        r = int'($urandom_range(0, 15));
        n = (r < 11) ? (r % (MAX_ARGS + 1)) : int'($urandom_range(MAX_ARGS + 1, 14));
        d[15:8] = 8'(n);
      end
      apply(v, d, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cmd_dispatch.md
CMD_DISPATCH -- requirements
Module: cmd_dispatch

Interface
REQ-001 SHALL have parameter CMD_BITS, default 8, width of command id.
REQ-002 SHALL have parameter MAX_ARGS, default 8, argument buffer depth in 32-bit words (power of two).
REQ-003 SHALL have parameter TIMEOUT, default 65535, max cycles to wait for cmd_done.
REQ-004 SHALL have ports: clk  in  1  sole clock; rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: in_data  in  32  word stream; in_valid  in  1  word available; in_ready  out  1  word accepted when in_valid & in_ready.
REQ-006 SHALL have ports: cmd  out  CMD_BITS  current command id; cmd_ready  out  1  command and all args available; cmd_done  in  1  unit finished.
REQ-007 SHALL have ports: arg_data  out  32  current argument word; arg_advance  in  1  step to next argument.
REQ-008 SHALL have ports: err_nargs  out  1  sticky, header arg count too large; err_timeout  out  1  sticky, unit never finished.

Function
REQ-009 Header word SHALL be: bits [CMD_BITS-1:0] = cmd id, bits [CMD_BITS+7:CMD_BITS] = nargs (0..255); remaining bits ignored.
REQ-010 States SHALL be IDLE, LOAD, DISPATCH, DRAIN.
REQ-011 IDLE: in_ready=1; on accepted header, latch cmd, nargs; nargs=0 -> DISPATCH; 1..MAX_ARGS -> LOAD; >MAX_ARGS -> set err_nargs, DRAIN.
REQ-012 LOAD: in_ready=1; each accepted word written to buf[wr_ptr], wr_ptr+1; on acceptance of word number nargs -> DISPATCH next cycle.
REQ-013 DRAIN: in_ready=1; accept and discard exactly nargs words, then IDLE; cmd_ready stays 0.
REQ-014 DISPATCH: in_ready=0; cmd_ready SHALL be combinational (state==DISPATCH) & !cmd_done, so it is low in the same cycle cmd_done is high.
REQ-015 On entry to DISPATCH rd_ptr=0; arg_data = buf[rd_ptr] while rd_ptr<nargs, else 0.
REQ-016 arg_advance SHALL increment rd_ptr only when cmd_ready=1; rd_ptr saturates at nargs; arg_advance ignored in other states.
REQ-017 cmd_done=1 in DISPATCH -> IDLE next cycle; cmd_done in any other state ignored.
REQ-018 Timeout counter SHALL clear on DISPATCH entry, increment each DISPATCH cycle; reaching TIMEOUT without cmd_done -> err_timeout=1, IDLE.
REQ-019 cmd_done and timeout in same cycle: cmd_done wins, err_timeout unchanged.
REQ-020 Latency: header (nargs=0) accepted cycle T -> cmd_ready=1 cycle T+1; last arg accepted cycle T -> cmd_ready=1 cycle T+1.
REQ-021 Back-to-back: cmd_done cycle T -> IDLE, in_ready=1 at T+1; next header accepted earliest T+1.
REQ-022 cmd SHALL hold latched value from header until next header accepted.
REQ-023 err_nargs, err_timeout SHALL stay set until rst; dispatch continues normally after either.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, wr_ptr=rd_ptr=0, nargs=0, cmd=0, timeout counter=0, err_nargs=0, err_timeout=0.
REQ-025 During rst and first cycle after: in_ready=0 during rst, cmd_ready=0, arg_data=0; in_ready=1 from first clock after rst deasserts.
REQ-026 rst mid-LOAD or mid-DISPATCH SHALL abandon the command; buffer contents need not be cleared.

Verification
REQ-027 Header cmd=2,nargs=4 then 0x5,0x3E8,0x1F4,0x1 with unit asserting arg_advance every cycle -> cmd_ready one cycle after last word, arg_data 0x5,0x3E8,0x1F4,0x1,0 on successive cycles.
REQ-028 Unit pulses cmd_done 5 cycles after cmd_ready -> cmd_ready low that same cycle, in_ready=1 next cycle, second queued header cmd=3,nargs=2 dispatched with no lost words.
REQ-029 Header nargs=12 (MAX_ARGS=8) followed by 12 words then valid cmd=2,nargs=0 -> err_nargs=1, 12 words discarded, cmd=2 dispatched, cmd_ready=1.
REQ-030 TIMEOUT=16, cmd_done never asserted -> cmd_ready high exactly 16 cycles, err_timeout=1, IDLE; cmd_done at cycle 16 instead -> err_timeout=0.
REQ-031 in_valid toggled randomly during LOAD of nargs=3 -> only accepted words stored, order preserved, cmd_ready only after third accepted word.
REQ-032 rst asserted mid-DISPATCH -> cmd_ready=0 same cycle, errors cleared, next header after release dispatched normally.
